mult_seq_control: RTL and testbench
===================================

Name: mult_seq_control

Overview:
- Parametrised sequencing controller for the add-shift multiplier datapath; the generalised successor of the fixed 8-count shift controller.
- Walks WIDTH add/shift iterations with an internal counter rather than one enumerated state per count.
- Supports an optional two's-complement final subtract, a synchronous abort and Run-level hold in DONE.
- Sits between the switch/button synchronisers and the register unit plus the adder.

Parameters:
- WIDTH, 8, operand width and iteration count; legal range is WIDTH >= 2.
- SIGNED, 1, when 1 the final iteration subtracts instead of adds; when 0 every iteration adds.
- CNT_W, $clog2(WIDTH), localparam, width of the iteration counter.

Ports:
- Clk  in  1  system clock, rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- Run  in  1  start request, level, already synchronised.
- ClearA_LoadB  in  1  in IDLE only: clear A/X and load B from switches.
- Abort  in  1  synchronous cancel of an operation in progress.
- M  in  1  current multiplier LSB (B[0]) from the register unit.
- Clr_XA  out  1  clear the X and A registers.
- Ld_B  out  1  load the B register.
- Add_En  out  1  load A with A+S.
- Sub_En  out  1  load A with A-S.
- Shift_En  out  1  arithmetic-shift X:A:B right by one.
- Busy  out  1  high in CLEAR, ADD and SHIFT.
- Done  out  1  high in DONE.
- Iter  out  CNT_W  current iteration index, 0..WIDTH-1.

Behaviour:
- Interface: one clock (Clk). Reset_n is asynchronous and active-low and forces state IDLE and Iter=0 immediately.
- All outputs are 0 during reset, except that Clr_XA and Ld_B follow ClearA_LoadB while in IDLE.
- States: IDLE, CLEAR, ADD, SHIFT, DONE.
- Outputs are Moore-decoded from state. The exceptions are the IDLE passthroughs and the M-dependent Add_En/Sub_En in ADD.
- IDLE:
  - Clr_XA = Ld_B = ClearA_LoadB; all other outputs 0.
  - Run=1 goes to CLEAR and sets Iter=0.
  - If Run and ClearA_LoadB are both high, Run wins: the load strobes still fire this cycle and the state goes to CLEAR.
- CLEAR: Clr_XA=1 for exactly one cycle, then go to ADD.
- ADD:
  - last = (Iter == WIDTH-1).
  - Add_En = M & ~(SIGNED & last).
  - Sub_En = M & SIGNED & last.
  - M=0 gives a no-op cycle; the add is never skipped in time.
  - Next state is SHIFT.
- SHIFT:
  - Shift_En=1.
  - If last, go to DONE; otherwise increment Iter and go to ADD.
  - Iter never wraps past WIDTH-1.
- DONE:
  - Done=1 and all strobes 0.
  - Stay while Run=1; go to IDLE on Run=0. This gives one multiply per Run press.
  - Iter holds WIDTH-1 until the next CLEAR.
- Latency: Run sampled in IDLE at edge t0 gives CLEAR in cycle t0+1, then 2*WIDTH ADD/SHIFT cycles, then DONE from edge t0+2*WIDTH+1 (17 cycles for WIDTH=8).
- Abort:
  - In CLEAR, ADD or SHIFT, go to IDLE at the next edge. Done is not asserted.
  - Strobes decoded in the aborting cycle still fire; the datapath contents are then undefined.
  - Abort is ignored in IDLE and DONE.
- Run dropping mid-operation has no effect; the sequence completes and DONE falls straight to IDLE at the next edge.
- No X propagation is allowed: illegal state encodings go to IDLE.
- Add_En and Sub_En are never both 1.
- Exactly one of Busy, Done or "in IDLE" is true in any cycle.

Decomposition:
- Shared package mult_pkg holds:
  - typedef enum logic [2:0] mult_state_t {S_IDLE, S_CLEAR, S_ADD, S_SHIFT, S_DONE};
  - the default width constant MULT_WIDTH=8.
- One sub-module, iter_counter (parameter WIDTH), with ports Clk, Reset_n, clr, inc, count, last.
- The FSM stays in a two-process structure: one always_ff for state, one always_comb for next-state and outputs.

Test Plan:
1. WIDTH=8, SIGNED=1, B=0x07 (M pattern 1,1,1,0,...), Run held high:
   - exactly 17 cycles from the Run edge to Done.
   - Add_En pulses in iterations 0..2 only; Sub_En never fires.
   - Shift_En fires 8 times.
2. WIDTH=8, SIGNED=1, B=0x80 (M=1 at iteration 7): Sub_En=1 only in the ADD cycle with Iter=7; Add_En is never 1.
3. WIDTH=16, SIGNED=0, B=0xFFFF:
   - 16 Add_En and 16 Shift_En pulses, Sub_En always 0.
   - Done after 33 cycles; Iter=15 in DONE.
4. Hold Run high for 40 cycles after Done: the state stays in DONE with no strobes. Drop Run: IDLE next cycle. Raise Run again: a second sequence starts.
5. Assert Abort in the ADD cycle with Iter=3: IDLE next cycle, Done never asserts, Busy falls. A following Run gives a full 17-cycle sequence from Iter=0.
6. Drive Reset_n low mid-SHIFT between clock edges:
   - state goes to IDLE and Iter to 0 immediately (asynchronous), all strobes 0.
   - In IDLE with ClearA_LoadB=1, Clr_XA=Ld_B=1 combinationally.

Source files
------------

// File: rtl/mult_pkg.sv
// mult_pkg: shared types and constants for the add-shift multiplier control.
//   mult_state_t : sequencer state encoding (IDLE, CLEAR, ADD, SHIFT, DONE)
//   MULT_WIDTH   : default operand width / iteration count
package mult_pkg;

    localparam int unsigned MULT_WIDTH = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_ADD,
        S_SHIFT,
        S_DONE
    } mult_state_t;

endpackage

// File: rtl/iter_counter.sv
// iter_counter: iteration index for the add/shift sequence.
// Ports:
//   Clk     in   rising-edge clock
//   Reset_n in   asynchronous active-low reset, forces count to 0
//   clr     in   synchronous clear to 0 (has priority over inc)
//   inc     in   advance by one; saturates at WIDTH-1
//   count   out  current index, 0..WIDTH-1
//   last    out  count == WIDTH-1
module iter_counter
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH = MULT_WIDTH,
    localparam int unsigned CNT_W = $clog2(WIDTH)
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count,
    output logic             last
);

    assign last = (count == CNT_W'(WIDTH - 1));

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && !last) begin
            // Saturating: the index never wraps past WIDTH-1
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/mult_seq_control.sv
// mult_seq_control: sequencing controller for the add-shift multiplier datapath.
// Walks WIDTH add/shift iterations using iter_counter. With SIGNED=1 the final
// iteration subtracts (two's-complement correction for the sign bit of B).
// Ports:
//   Clk, Reset_n   clock and asynchronous active-low reset
//   Run            start request (level); one multiply per press
//   ClearA_LoadB   in IDLE: clear X/A and load B
//   Abort          synchronous cancel while busy
//   M              current multiplier LSB from the register unit
//   Clr_XA, Ld_B   register unit clear / load strobes
//   Add_En, Sub_En load A with A+S / A-S
//   Shift_En       arithmetic-shift X:A:B right
//   Busy, Done     status; Iter is the current iteration index
module mult_seq_control
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH = MULT_WIDTH,
    parameter bit          SIGNED = 1'b1,
    localparam int unsigned CNT_W = $clog2(WIDTH)
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Run,
    input  logic             ClearA_LoadB,
    input  logic             Abort,
    input  logic             M,
    output logic             Clr_XA,
    output logic             Ld_B,
    output logic             Add_En,
    output logic             Sub_En,
    output logic             Shift_En,
    output logic             Busy,
    output logic             Done,
    output logic [CNT_W-1:0] Iter
);

    mult_state_t state_q, state_d;
    logic        cnt_clr, cnt_inc, last;

    iter_counter #(
        .WIDTH (WIDTH)
    ) u_iter_counter (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .clr     (cnt_clr),
        .inc     (cnt_inc),
        .count   (Iter),
        .last    (last)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_clr  = 1'b0;
        cnt_inc  = 1'b0;
        Clr_XA   = 1'b0;
        Ld_B     = 1'b0;
        Add_En   = 1'b0;
        Sub_En   = 1'b0;
        Shift_En = 1'b0;
        Busy     = 1'b0;
        Done     = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Load strobes pass through even when Run starts a sequence
                Clr_XA = ClearA_LoadB;
                Ld_B   = ClearA_LoadB;
                if (Run) begin
                    state_d = S_CLEAR;
                    cnt_clr = 1'b1;
                end
            end
            S_CLEAR: begin
                Clr_XA  = 1'b1;
                Busy    = 1'b1;
                state_d = Abort ? S_IDLE : S_ADD;
            end
            S_ADD: begin
                Busy = 1'b1;
                // Sign-bit weight is negative: subtract on the last iteration
                Add_En  = M & ~(SIGNED & last);
                Sub_En  = M & SIGNED & last;
                state_d = Abort ? S_IDLE : S_SHIFT;
            end
            S_SHIFT: begin
                Busy     = 1'b1;
                Shift_En = 1'b1;
                if (Abort) begin
                    state_d = S_IDLE;
                end else if (last) begin
                    state_d = S_DONE;
                end else begin
                    cnt_inc = 1'b1;
                    state_d = S_ADD;
                end
            end
            S_DONE: begin
                Done = 1'b1;
                // Hold until Run is released so a held button multiplies once
                if (!Run) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mult_seq_control.sv
// tb_mult_seq_control: directed checks of mult_seq_control with an 8-bit signed
// and a 16-bit unsigned instance. Output vectors are {Clr_XA, Ld_B, Add_En,
// Sub_En, Shift_En, Busy, Done}.
module tb_mult_seq_control;

    logic       Clk = 1'b0;
    logic       Reset_n, Run8, Run16, CALB, Abort, M8, M16;
    logic       c8, l8, a8, s8, sh8, b8, d8;
    logic       c16, l16, a16, s16, sh16, b16, d16;
    logic [2:0] it8;
    logic [3:0] it16;

    int total = 0;
    int bad   = 0;

    always #5 Clk = ~Clk;

    mult_seq_control #(
        .WIDTH  (8),
        .SIGNED (1'b1)
    ) dut8 (
        .Clk          (Clk),
        .Reset_n      (Reset_n),
        .Run          (Run8),
        .ClearA_LoadB (CALB),
        .Abort        (Abort),
        .M            (M8),
        .Clr_XA       (c8),
        .Ld_B         (l8),
        .Add_En       (a8),
        .Sub_En       (s8),
        .Shift_En     (sh8),
        .Busy         (b8),
        .Done         (d8),
        .Iter         (it8)
    );

    mult_seq_control #(
        .WIDTH  (16),
        .SIGNED (1'b0)
    ) dut16 (
        .Clk          (Clk),
        .Reset_n      (Reset_n),
        .Run          (Run16),
        .ClearA_LoadB (CALB),
        .Abort        (1'b0),
        .M            (M16),
        .Clr_XA       (c16),
        .Ld_B         (l16),
        .Add_En       (a16),
        .Sub_En       (s16),
        .Shift_En     (sh16),
        .Busy         (b16),
        .Done         (d16),
        .Iter         (it16)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] vec(input bit w);
        if (w) return {c16, l16, a16, s16, sh16, b16, d16};
        return {c8, l8, a8, s8, sh8, b8, d8};
    endfunction

    function automatic logic [31:0] iter(input bit w);
        if (w) return 32'(it16);
        return 32'(it8);
    endfunction

    // One full sequence from an IDLE start; leaves Run high in DONE unless aborted.
    task automatic run_seq(input bit w, input logic [15:0] b, input int abort_at,
                           input bit with_load, input int exp_add, input int exp_sub,
                           input int exp_sh);
        int         W;
        bit         sg;
        int         nadd, nsub, nsh;
        logic [6:0] v;
        W    = w ? 16 : 8;
        sg   = !w;
        nadd = 0;
        nsub = 0;
        nsh  = 0;
        @(negedge Clk);
        if (w) Run16 = 1'b1;
        else   Run8  = 1'b1;
        CALB = with_load;
        #1;
        chk("idle_start", vec(w), {with_load, with_load, 5'b0});
        @(negedge Clk);
        CALB = 1'b0;
        for (int k = 0; k <= 2 * W + 1; k++) begin
            int   i;
            logic ea, es;
            if (k == 0) begin
                #1;
                chk("clear", vec(w), 7'b1000010);
                chk("clear_iter", iter(w), 0);
            end else if (k == 2 * W + 1) begin
                #1;
                chk("done", vec(w), 7'b0000001);
                chk("done_iter", iter(w), W - 1);
            end else if (k % 2 == 1) begin
                i = (k - 1) / 2;
                if (w) M16 = b[i];
                else   M8  = b[i];
                if (i == abort_at) Abort = 1'b1;
                ea = b[i] & ~(sg && i == W - 1);
                es = b[i] & sg & (i == W - 1);
                #1;
                v = vec(w);
                nadd += int'(v[4]);
                nsub += int'(v[3]);
                chk("add", v, {2'b00, ea, es, 3'b010});
                chk("add_iter", iter(w), i);
                if (i == abort_at) begin
                    @(negedge Clk);
                    Abort = 1'b0;
                    Run8  = 1'b0;
                    M8    = 1'b0;
                    #1;
                    chk("abort_idle", vec(w), 7'b0);
                    repeat (3) begin
                        @(negedge Clk);
                        #1;
                        chk("abort_no_done", vec(w), 7'b0);
                    end
                    return;
                end
            end else begin
                i = (k - 2) / 2;
                #1;
                v = vec(w);
                nsh += int'(v[2]);
                chk("shift", v, 7'b0000110);
                chk("shift_iter", iter(w), i);
            end
            if (k < 2 * W + 1) @(negedge Clk);
        end
        M8  = 1'b0;
        M16 = 1'b0;
        chk("n_add", nadd, exp_add);
        chk("n_sub", nsub, exp_sub);
        chk("n_shift", nsh, exp_sh);
    endtask

    initial begin
        Reset_n = 1'b0;
        Run8    = 1'b0;
        Run16   = 1'b0;
        CALB    = 1'b0;
        Abort   = 1'b0;
        M8      = 1'b0;
        M16     = 1'b0;
        #2;
        chk("rst_vec", vec(0), 7'b0);
        chk("rst_iter", iter(0), 0);
        CALB = 1'b1;
        #1;
        chk("rst_pass", vec(0), 7'b1100000);
        CALB = 1'b0;
        @(negedge Clk);
        Reset_n = 1'b1;

        // B=0x07 signed, Run+ClearA_LoadB together (Run wins), Run held
        run_seq(0, 16'h0007, -1, 1'b1, 3, 0, 8);

        // Held Run keeps DONE, then release returns to IDLE
        repeat (40) begin
            @(negedge Clk);
            #1;
            chk("hold_done", vec(0), 7'b0000001);
        end
        chk("hold_iter", iter(0), 7);
        Run8 = 1'b0;
        @(negedge Clk);
        #1;
        chk("drop_idle", vec(0), 7'b0);

        // B=0x80 signed: only a subtract at iteration 7
        run_seq(0, 16'h0080, -1, 1'b0, 0, 1, 8);
        Run8 = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
        #1;
        chk("idle_after_sub", vec(0), 7'b0);

        // Abort in ADD at Iter=3, then a clean full sequence
        run_seq(0, 16'h00FF, 3, 1'b0, 0, 0, 0);
        run_seq(0, 16'h0007, -1, 1'b0, 3, 0, 8);
        Run8 = 1'b0;
        @(negedge Clk);

        // 16-bit unsigned, B=0xFFFF
        run_seq(1, 16'hFFFF, -1, 1'b0, 16, 0, 16);
        Run16 = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
        #1;
        chk("idle16", vec(1), 7'b0);

        // Asynchronous reset in the middle of a SHIFT cycle
        @(negedge Clk);
        Run8 = 1'b1;
        @(negedge Clk);
        repeat (4) @(negedge Clk);
        #1;
        chk("pre_rst_shift", vec(0), 7'b0000110);
        chk("pre_rst_iter", iter(0), 1);
        #1;
        Reset_n = 1'b0;
        #1;
        chk("async_rst_vec", vec(0), 7'b0);
        chk("async_rst_iter", iter(0), 0);
        CALB = 1'b1;
        #1;
        chk("async_rst_pass", vec(0), 7'b1100000);
        CALB = 1'b0;
        Run8 = 1'b0;
        @(negedge Clk);
        Reset_n = 1'b1;
        @(negedge Clk);
        #1;
        chk("post_rst_idle", vec(0), 7'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
